// File: rtl/key_mode_ctrl_if.sv
// Key/selection bundle between the button front end and the DDS mode select.
// master drives the raw buttons; slave is the key_mode_ctrl side.
interface key_mode_ctrl_if #(
  parameter int unsigned KEY_NUM = 4
);
  localparam int unsigned IW = $clog2(KEY_NUM);

  logic [KEY_NUM-1:0] key;
  logic [KEY_NUM-1:0] key_level;
  logic [KEY_NUM-1:0] key_flag;
  logic [KEY_NUM-1:0] key_long;
  logic [KEY_NUM-1:0] sel_onehot;
  logic [IW-1:0]      sel_idx;
  logic               sel_lock;

  modport master (
    output key,
    input  key_level, key_flag, key_long, sel_onehot, sel_idx, sel_lock
  );

  modport slave (
    input  key,
    output key_level, key_flag, key_long, sel_onehot, sel_idx, sel_lock
  );
endinterface

// File: rtl/key_mode_ctrl.sv
// Multi-key debounce with one-hot/binary mode selection for the DDS core.
// Optional long-press lock/unlock is built when KEY_LONG_PRESS_EN is defined.
module key_mode_ctrl #(
  parameter int unsigned KEY_NUM  = 4,
  parameter int unsigned CNT_MAX  = 999_999,
  parameter int unsigned LONG_MAX = 49_999_999,
  parameter int unsigned DEF_SEL  = 0
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  key_mode_ctrl_if.slave bus
);

  localparam int unsigned IW = $clog2(KEY_NUM);
  localparam int unsigned CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_TOP = CW'(CNT_MAX);

  logic [KEY_NUM-1:0] sync1;
  logic [KEY_NUM-1:0] sync2;
  logic [KEY_NUM-1:0] level;
  logic [KEY_NUM-1:0] level_d;
  logic [KEY_NUM-1:0] fall;
  logic [KEY_NUM-1:0] flag;
  logic [CW-1:0]      cnt [KEY_NUM];

  logic [KEY_NUM-1:0] win_oh;
  logic [IW-1:0]      win_idx;
  logic [KEY_NUM-1:0] sel_onehot;
  logic [IW-1:0]      sel_idx;

  logic [KEY_NUM-1:0] key_long;
  logic               sel_lock;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1   <= '1;
      sync2   <= '1;
      level   <= '1;
      level_d <= '1;
      for (int unsigned i = 0; i < KEY_NUM; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1   <= bus.key;
      sync2   <= sync1;
      level_d <= level;
      // Any sample that agrees with the current level restarts the count.
      for (int unsigned i = 0; i < KEY_NUM; i++) begin
        if (sync2[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_TOP) begin
          level[i] <= sync2[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  assign fall = level_d & ~level;

  // Lowest set bit wins: isolate it for the one-hot, scan downward for the index.
  assign win_oh = fall & (~fall + KEY_NUM'(1));

  always_comb begin
    win_idx = '0;
    for (int unsigned i = KEY_NUM; i > 0; i--) begin
      if (fall[i-1]) begin
        win_idx = IW'(i - 1);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      flag       <= '0;
      sel_onehot <= KEY_NUM'(1) << DEF_SEL;
      sel_idx    <= IW'(DEF_SEL);
    end else begin
      flag <= fall;
      if ((|fall) && !sel_lock) begin
        sel_onehot <= win_oh;
        sel_idx    <= win_idx;
      end
    end
  end

`ifdef KEY_LONG_PRESS_EN
  localparam int unsigned LW = $clog2(LONG_MAX + 1);
  localparam logic [LW-1:0] LONG_TOP = LW'(LONG_MAX);

  logic [LW-1:0]      hold [KEY_NUM];
  logic [KEY_NUM-1:0] hold_done;
  logic [KEY_NUM-1:0] long_hit;
  logic [KEY_NUM-1:0] long_q;
  logic               lock_q;

  always_comb begin
    long_hit = '0;
    for (int unsigned i = 0; i < KEY_NUM; i++) begin
      long_hit[i] = !level[i] && (hold[i] == LONG_TOP) && !hold_done[i];
    end
  end

  // hold_done keeps the saturated counter from re-firing until release.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hold_done <= '0;
      long_q    <= '0;
      lock_q    <= 1'b0;
      for (int unsigned i = 0; i < KEY_NUM; i++) begin
        hold[i] <= '0;
      end
    end else begin
      long_q <= long_hit;
      lock_q <= lock_q ^ (|long_hit);
      for (int unsigned i = 0; i < KEY_NUM; i++) begin
        if (level[i]) begin
          hold[i]      <= '0;
          hold_done[i] <= 1'b0;
        end else if (hold[i] != LONG_TOP) begin
          hold[i] <= hold[i] + LW'(1);
        end else if (long_hit[i]) begin
          hold_done[i] <= 1'b1;
        end
      end
    end
  end

  assign key_long = long_q;
  assign sel_lock = lock_q;
`else
  assign key_long = '0;
  assign sel_lock = 1'b0;
`endif

  assign bus.key_level  = level;
  assign bus.key_flag   = flag;
  assign bus.key_long   = key_long;
  assign bus.sel_onehot = sel_onehot;
  assign bus.sel_idx    = sel_idx;
  assign bus.sel_lock   = sel_lock;

endmodule

// File: tb/tb_key_mode_ctrl.sv
// Directed bench for key_mode_ctrl: debounce latency, selection priority,
// long-press lock (when KEY_LONG_PRESS_EN is defined) and asynchronous reset.
module tb_key_mode_ctrl;

  logic sys_clk;
  logic sys_rst_n;

  key_mode_ctrl_if #(.KEY_NUM(4)) kif ();

  key_mode_ctrl #(
    .KEY_NUM (4),
    .CNT_MAX (24),
    .LONG_MAX(99),
    .DEF_SEL (0)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (kif.slave)
  );

  initial sys_clk = 1'b0;
  always #10 sys_clk = ~sys_clk;

  int pass_cnt;
  int total_cnt;
  int flag_seen [4];
  int f_before;

  initial begin
    for (int i = 0; i < 4; i++) flag_seen[i] = 0;
  end

  always @(negedge sys_clk) begin
    for (int i = 0; i < 4; i++) begin
      if (kif.key_flag[i]) flag_seen[i] <= flag_seen[i] + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_level"},  32'(kif.key_level),  'hF);
    check({tag, "_flag"},   32'(kif.key_flag),   'h0);
    check({tag, "_onehot"}, 32'(kif.sel_onehot), 'h1);
    check({tag, "_idx"},    32'(kif.sel_idx),    'h0);
    check({tag, "_lock"},   32'(kif.sel_lock),   'h0);
    check({tag, "_long"},   32'(kif.key_long),   'h0);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    sys_rst_n = 1'b0;
    kif.key   = 4'hF;

    // Reset state, then idle after release.
    tick(3);
    check_reset_vals("in_reset");
    #4 sys_rst_n = 1'b1;
    tick(5);
    check_reset_vals("idle");

    // key[2]: bounce, then a clean 60-cycle hold.
    f_before = flag_seen[2];
    for (int i = 0; i < 20; i++) begin
      kif.key[2] = 1'($urandom_range(0, 1));
      tick(1);
    end
    kif.key[2] = 1'b1;
    tick(1);
    kif.key[2] = 1'b0;
    tick(26);
    check("k2_level_e26", 32'(kif.key_level), 'hF);
    tick(1);
    check("k2_level_e27", 32'(kif.key_level), 'hB);
    check("k2_flag_e27",  32'(kif.key_flag),  'h0);
    check("k2_idx_e27",   32'(kif.sel_idx),   'h0);
    tick(1);
    check("k2_flag_e28",   32'(kif.key_flag),   'h4);
    check("k2_onehot_e28", 32'(kif.sel_onehot), 'h4);
    check("k2_idx_e28",    32'(kif.sel_idx),    'h2);
    tick(1);
    check("k2_flag_e29", 32'(kif.key_flag), 'h0);
    tick(31);
    for (int i = 0; i < 20; i++) begin
      kif.key[2] = 1'($urandom_range(0, 1));
      tick(1);
    end
    kif.key[2] = 1'b1;
    tick(40);
    check("k2_pulse_count", 32'(flag_seen[2] - f_before), 'h1);
    check("k2_released",    32'(kif.key_level),           'hF);
    check("k2_sel_kept",    32'(kif.sel_idx),             'h2);

    // key[1]: glitch shorter than the debounce window.
    f_before = flag_seen[1];
    kif.key[1] = 1'b0;
    tick(15);
    kif.key[1] = 1'b1;
    tick(40);
    check("short_level",  32'(kif.key_level),           'hF);
    check("short_flags",  32'(flag_seen[1] - f_before), 'h0);
    check("short_onehot", 32'(kif.sel_onehot),          'h4);

    // key[1] and key[3] together: both flag, lowest index selected.
    kif.key = 4'b0101;
    tick(27);
    check("dual_level_e27", 32'(kif.key_level), 'h5);
    check("dual_flag_e27",  32'(kif.key_flag),  'h0);
    tick(1);
    check("dual_flag_e28",   32'(kif.key_flag),   'hA);
    check("dual_onehot_e28", 32'(kif.sel_onehot), 'h2);
    check("dual_idx_e28",    32'(kif.sel_idx),    'h1);
    tick(1);
    check("dual_flag_e29", 32'(kif.key_flag), 'h0);
    kif.key = 4'hF;
    tick(40);
    check("dual_released", 32'(kif.key_level), 'hF);

`ifdef KEY_LONG_PRESS_EN
    // Long press on key[0] locks; key[3] then cannot move the selection.
    kif.key[0] = 1'b0;
    tick(27);
    check("lp_level_e27", 32'(kif.key_level), 'hE);
    tick(1);
    check("lp_flag_e28",   32'(kif.key_flag),   'h1);
    check("lp_onehot_e28", 32'(kif.sel_onehot), 'h1);
    tick(98);
    check("lp_long_e126", 32'(kif.key_long), 'h0);
    check("lp_lock_e126", 32'(kif.sel_lock), 'h0);
    tick(1);
    check("lp_long_e127", 32'(kif.key_long), 'h1);
    check("lp_lock_e127", 32'(kif.sel_lock), 'h1);
    tick(1);
    check("lp_long_e128", 32'(kif.key_long), 'h0);
    tick(73);
    check("lp_no_repeat", 32'(kif.key_long), 'h0);
    kif.key[0] = 1'b1;
    tick(40);
    check("lp_lock_kept", 32'(kif.sel_lock), 'h1);
    kif.key[3] = 1'b0;
    tick(28);
    check("lk_flag",   32'(kif.key_flag),   'h8);
    check("lk_onehot", 32'(kif.sel_onehot), 'h1);
    check("lk_idx",    32'(kif.sel_idx),    'h0);
    kif.key[3] = 1'b1;
    tick(40);
    kif.key[0] = 1'b0;
    tick(127);
    check("ul_long", 32'(kif.key_long), 'h1);
    check("ul_lock", 32'(kif.sel_lock), 'h0);
    kif.key[0] = 1'b1;
    tick(40);
`else
    // Without the long-press option a hold never locks.
    kif.key[0] = 1'b0;
    tick(28);
    check("hold_flag_e28",   32'(kif.key_flag),   'h1);
    check("hold_onehot_e28", 32'(kif.sel_onehot), 'h1);
    tick(99);
    check("hold_long_e127", 32'(kif.key_long), 'h0);
    check("hold_lock_e127", 32'(kif.sel_lock), 'h0);
    tick(73);
    kif.key[0] = 1'b1;
    tick(40);
    kif.key[3] = 1'b0;
    tick(28);
    check("k3_flag",   32'(kif.key_flag),   'h8);
    check("k3_onehot", 32'(kif.sel_onehot), 'h8);
    check("k3_idx",    32'(kif.sel_idx),    'h3);
    kif.key[3] = 1'b1;
    tick(40);
`endif

    // Move selection to 2, then reset in the middle of a key[3] debounce.
    kif.key[2] = 1'b0;
    tick(28);
    check("pre_rst_idx", 32'(kif.sel_idx), 'h2);
    kif.key[2] = 1'b1;
    tick(40);
    kif.key[3] = 1'b0;
    tick(10);
    #4 sys_rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    tick(3);
    #4 sys_rst_n = 1'b1;
    tick(27);
    check("post_rst_level_e27", 32'(kif.key_level), 'h7);
    check("post_rst_flag_e27",  32'(kif.key_flag),  'h0);
    tick(1);
    check("post_rst_flag_e28", 32'(kif.key_flag), 'h8);
    check("post_rst_idx_e28",  32'(kif.sel_idx),  'h3);
    tick(1);
    check("post_rst_flag_e29", 32'(kif.key_flag), 'h0);
    kif.key[3] = 1'b1;
    tick(5);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/key_mode_ctrl.md
# key_mode_ctrl

Parametrised multi-key front end for the DDS control path: debounces KEY_NUM active-low push-buttons and keeps a one-hot and a binary mode selection. Each debounced press produces a one-cycle event. An optional long-press feature locks and unlocks the selection. It drives the waveform/mode select of the DDS core and is the generalised successor of the fixed 4-key wave selector.

## Interface
- KEY_NUM, 4, number of keys; range 2..16
- CNT_MAX, 999_999, debounce length minus one in sys_clk cycles (20 ms at 50 MHz)
- LONG_MAX, 49_999_999, long-press hold length minus one in cycles (1 s at 50 MHz); used only with KEY_LONG_PRESS_EN
- DEF_SEL, 0, selection index loaded at reset; must be below KEY_NUM
- sys_clk  in  1  system clock, 50 MHz
- sys_rst_n  in  1  asynchronous, active-low reset
- key  in  KEY_NUM  raw buttons, active-low, asynchronous to sys_clk
- key_level  out  KEY_NUM  debounced level per key, 1 = released
- key_flag  out  KEY_NUM  one-cycle press pulse per key, on the debounced 1→0 transition
- key_long  out  KEY_NUM  one-cycle long-press pulse per key; constant 0 without KEY_LONG_PRESS_EN
- sel_onehot  out  KEY_NUM  current selection, exactly one bit set
- sel_idx  out  $clog2(KEY_NUM)  binary index of sel_onehot
- sel_lock  out  1  selection lock; constant 0 without KEY_LONG_PRESS_EN

## Operation
- Synchroniser: 2 flops per key, reset value 1.
- Debounce, per key:
  - Counter width $clog2(CNT_MAX+1).
  - When sync != key_level: the counter increments.
  - When the counter == CNT_MAX and sync != key_level: key_level takes sync and the counter clears.
  - When sync == key_level: the counter clears, so any bounce restarts the count.
- Release and press are debounced identically. Only a press (1→0) raises key_flag.
- Selection update, on any cycle where key_flag != 0 and sel_lock == 0:
  - The lowest-index flagged key wins.
  - sel_onehot and sel_idx load that key in the same edge as key_flag rises.
  - Pressing the already-selected key leaves the selection unchanged; key_flag still pulses.
- While sel_lock == 1, key_flag pulses continue but the selection holds.
- Reset values:
  - key_level = all 1
  - key_flag = 0, key_long = 0, sel_lock = 0
  - sel_onehot = 1<<DEF_SEL, sel_idx = DEF_SEL
  - all counters 0

## Timing
- Press latency: edge 1 is the first rising edge that samples raw key low, with the key stable low afterwards.
  - key_level falls at edge CNT_MAX+3.
  - key_flag is high for the cycle after edge CNT_MAX+4. sel_onehot/sel_idx update at that same edge.
- key_flag is exactly one cycle wide, and there is one pulse per debounced press regardless of bounce count.
- Long press: the hold counter runs while key_level == 0.
  - key_long pulses at the edge where the hold counter reaches LONG_MAX, i.e. LONG_MAX+1 cycles after key_level fell.
  - The counter then saturates: no repeat pulse until release.
  - Release clears the counter. A release before LONG_MAX gives no key_long.
- Simultaneous key_flag on several keys: all flag bits pulse together; the selection takes the lowest index.
- Simultaneous key_long on several keys: sel_lock toggles once.
- Reset mid-debounce or mid-hold: everything returns to reset values immediately (asynchronous). A key held through reset release is re-debounced and produces key_flag.

## Configuration
- KEY_LONG_PRESS_EN defined:
  - The per-key hold counters are built, width $clog2(LONG_MAX+1).
  - key_long is active as described above.
  - Any key_long pulse toggles sel_lock in the same edge.
  - A key_flag on the same cycle as a key_long toggle is evaluated against the pre-toggle sel_lock.
- KEY_LONG_PRESS_EN undefined:
  - No hold counters are built.
  - key_long = 0 and sel_lock = 0 permanently.
  - Every press may change the selection.

## Test plan
All scenarios use KEY_NUM=4, CNT_MAX=24, LONG_MAX=99, DEF_SEL=0, and a 20 ns clock.
- Reset released, no keys pressed -> key_level=4'b1111, sel_onehot=4'b0001, sel_idx=0, key_flag=0 held.
- key[2] bounces randomly for 20 cycles, then is held low for 60 cycles -> exactly one key_flag=4'b0100 pulse; sel_onehot=4'b0100 and sel_idx=2 at the same edge; no pulse on release bounce.
- key[1] pulses low for 15 cycles only -> key_level, key_flag and sel unchanged.
- key[1] and key[3] driven low on the same edge and held -> key_flag=4'b1010 for one cycle; sel_onehot=4'b0010, sel_idx=1.
- KEY_LONG_PRESS_EN: key[0] held 200 cycles -> one key_long=4'b0001 pulse 100 cycles after key_level[0] falls; sel_lock=1. A later key[3] press gives key_flag=4'b1000 with sel unchanged. A second long press on key[0] gives sel_lock=0.
- sys_rst_n asserted 10 cycles into a key[3] debounce while sel_idx=2 -> outputs return to reset values immediately. After reset release with key[3] still low, key_flag[3] occurs at edge CNT_MAX+4 and sel_idx=3.
